// File: rtl/nw_pkg.sv
// Shared types and constants for the Needleman-Wunsch traceback block.
// Optional checking is controlled by the TRACEBACK_CHECK_EN macro.
package nw_pkg;

    localparam int SCORE_W        = 9;
    localparam int MATCH_SCORE    = 1;
    localparam int MISMATCH_SCORE = -1;
    localparam int GAP_SCORE      = -1;

    typedef enum logic [1:0] {
        SYM_A = 2'd0,
        SYM_C = 2'd1,
        SYM_G = 2'd2,
        SYM_T = 2'd3
    } sym_t;

    typedef enum logic [1:0] {
        DIR_MATCH = 2'b00,
        DIR_MISM  = 2'b01,
        DIR_UP    = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_DECIDE,
        ST_EMIT,
        ST_DONE
    } tb_state_t;

    // Scores are compared one bit wider so that a neighbour plus penalty never wraps.
    function automatic logic signed [SCORE_W:0] sext(input logic signed [SCORE_W-1:0] v);
        return {v[SCORE_W-1], v};
    endfunction

endpackage

// File: rtl/nw_traceback_if.sv
// Score-RAM read bus and alignment-step output stream of the traceback engine.
// master: traceback engine; slave: score/sequence memories plus alignment writer.
interface nw_traceback_if
    import nw_pkg::*;
#(
    parameter int BitAddr = 3
);

    logic                      rd_en;
    logic [BitAddr:0]          rd_i;
    logic [BitAddr:0]          rd_j;
    logic signed [SCORE_W-1:0] cur;
    logic signed [SCORE_W-1:0] diag;
    logic signed [SCORE_W-1:0] up;
    logic signed [SCORE_W-1:0] left;
    logic [1:0]                char_a;
    logic [1:0]                char_b;

    logic                      out_valid;
    logic                      out_ready;
    logic [1:0]                out_dir;
    logic [BitAddr:0]          out_i;
    logic [BitAddr:0]          out_j;

    modport master (
        output rd_en, rd_i, rd_j,
        input  cur, diag, up, left, char_a, char_b,
        output out_valid, out_dir, out_i, out_j,
        input  out_ready
    );

    modport slave (
        input  rd_en, rd_i, rd_j,
        output cur, diag, up, left, char_a, char_b,
        input  out_valid, out_dir, out_i, out_j,
        output out_ready
    );

endinterface

// File: rtl/nw_tb_decide.sv
// Combinational traceback direction chooser (priority diag > up > left).
// With TRACEBACK_CHECK_EN it also flags interior cells that no predecessor explains.
module nw_tb_decide
    import nw_pkg::*;
#(
    parameter int MATCH    = MATCH_SCORE,
    parameter int MISMATCH = MISMATCH_SCORE,
    parameter int GAP      = GAP_SCORE
) (
    input  logic signed [SCORE_W-1:0] cur,
    input  logic signed [SCORE_W-1:0] diag,
    input  logic signed [SCORE_W-1:0] up,
    input  logic signed [SCORE_W-1:0] left,
    input  logic [1:0]                char_a,
    input  logic [1:0]                char_b,
    input  logic                      i_zero,
    input  logic                      j_zero,
    output dir_t                      dir
`ifdef TRACEBACK_CHECK_EN
    ,
    output logic                      chk_fail
`endif
);

    localparam logic signed [SCORE_W:0] MATCH_V = (SCORE_W+1)'(MATCH);
    localparam logic signed [SCORE_W:0] MISM_V  = (SCORE_W+1)'(MISMATCH);
    localparam logic signed [SCORE_W:0] GAP_V   = (SCORE_W+1)'(GAP);

    logic signed [SCORE_W:0] cur_x;
    logic signed [SCORE_W:0] diag_sum;
    logic signed [SCORE_W:0] up_sum;
    logic                    char_eq;
    logic                    diag_ok;
    logic                    up_ok;

    // Boundary rows/columns never look at neighbour data, which may be garbage there.
    always_comb begin
        char_eq  = (char_a == char_b);
        cur_x    = sext(cur);
        diag_sum = sext(diag) + (char_eq ? MATCH_V : MISM_V);
        up_sum   = sext(up) + GAP_V;
        diag_ok  = !i_zero && !j_zero && (cur_x == diag_sum);
        up_ok    = !i_zero && (cur_x == up_sum);

        dir = DIR_LEFT;
        if (i_zero) begin
            dir = DIR_LEFT;
        end else if (j_zero) begin
            dir = DIR_UP;
        end else if (diag_ok) begin
            dir = char_eq ? DIR_MATCH : DIR_MISM;
        end else if (up_ok) begin
            dir = DIR_UP;
        end
    end

`ifdef TRACEBACK_CHECK_EN
    logic signed [SCORE_W:0] left_sum;

    always_comb begin
        left_sum = sext(left) + GAP_V;
        chk_fail = !i_zero && !j_zero && !diag_ok && !up_ok && (cur_x != left_sum);
    end
`else
    logic unused_left;
    assign unused_left = ^left;
`endif

endmodule

// File: rtl/nw_traceback.sv
// Needleman-Wunsch traceback: walks the filled score matrix from (N,N) to (0,0),
// emitting one alignment step per handshake. TRACEBACK_CHECK_EN adds the err output.
module nw_traceback
    import nw_pkg::*;
#(
    parameter int N        = 4,
    parameter int BitAddr  = $clog2(N+1),
    parameter int MATCH    = MATCH_SCORE,
    parameter int MISMATCH = MISMATCH_SCORE,
    parameter int GAP      = GAP_SCORE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    nw_traceback_if.master       bus,
    output logic                 busy,
    output logic                 done,
    output logic [BitAddr+1:0]   len
`ifdef TRACEBACK_CHECK_EN
    ,
    output logic                 err
`endif
);

    localparam logic [BitAddr:0]   IDX_ONE = (BitAddr+1)'(1);
    localparam logic [BitAddr:0]   IDX_N   = (BitAddr+1)'(N);
    localparam logic [BitAddr+1:0] LEN_ONE = (BitAddr+2)'(1);

    tb_state_t state;
    tb_state_t state_next;

    logic [BitAddr:0]          i;
    logic [BitAddr:0]          j;
    logic [BitAddr:0]          i_step;
    logic [BitAddr:0]          j_step;
    logic                      step_last;

    logic signed [SCORE_W-1:0] cur_q;
    logic signed [SCORE_W-1:0] diag_q;
    logic signed [SCORE_W-1:0] up_q;
    logic signed [SCORE_W-1:0] left_q;
    logic [1:0]                char_a_q;
    logic [1:0]                char_b_q;

    dir_t                      dec_dir;
    dir_t                      dir_q;
    logic [BitAddr:0]          out_i_q;
    logic [BitAddr:0]          out_j_q;

`ifdef TRACEBACK_CHECK_EN
    logic chk_fail;
    logic err_q;
    assign err = err_q;
`endif

    nw_tb_decide #(
        .MATCH    (MATCH),
        .MISMATCH (MISMATCH),
        .GAP      (GAP)
    ) u_decide (
        .cur      (cur_q),
        .diag     (diag_q),
        .up       (up_q),
        .left     (left_q),
        .char_a   (char_a_q),
        .char_b   (char_b_q),
        .i_zero   (i == '0),
        .j_zero   (j == '0),
        .dir      (dec_dir)
`ifdef TRACEBACK_CHECK_EN
        ,
        .chk_fail (chk_fail)
`endif
    );

    // Coordinates after the step currently on offer; committed only on handshake.
    always_comb begin
        i_step = i;
        j_step = j;
        case (dir_q)
            DIR_MATCH, DIR_MISM: begin
                i_step = i - IDX_ONE;
                j_step = j - IDX_ONE;
            end
            DIR_UP:   i_step = i - IDX_ONE;
            DIR_LEFT: j_step = j - IDX_ONE;
            default:  ;
        endcase
        step_last = (i_step == '0) && (j_step == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_READ;
                end
            end
            ST_READ:   state_next = ST_WAIT;
            ST_WAIT:   state_next = ST_DECIDE;
            ST_DECIDE: begin
                state_next = ST_EMIT;
`ifdef TRACEBACK_CHECK_EN
                if (chk_fail) begin
                    state_next = ST_DONE;
                end
`endif
            end
            ST_EMIT: begin
                if (bus.out_ready) begin
                    state_next = step_last ? ST_DONE : ST_READ;
                end
            end
            default:   state_next = ST_IDLE;
        endcase
    end

    assign bus.rd_en     = (state == ST_READ);
    assign bus.rd_i      = i;
    assign bus.rd_j      = j;
    assign bus.out_valid = (state == ST_EMIT);
    assign bus.out_dir   = dir_q;
    assign bus.out_i     = out_i_q;
    assign bus.out_j     = out_j_q;

    // RAM data is only trusted in WAIT, so it is captured there and decided on next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            i        <= '0;
            j        <= '0;
            len      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cur_q    <= '0;
            diag_q   <= '0;
            up_q     <= '0;
            left_q   <= '0;
            char_a_q <= '0;
            char_b_q <= '0;
            dir_q    <= DIR_MATCH;
            out_i_q  <= '0;
            out_j_q  <= '0;
`ifdef TRACEBACK_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        i    <= IDX_N;
                        j    <= IDX_N;
                        len  <= '0;
                        busy <= 1'b1;
`ifdef TRACEBACK_CHECK_EN
                        err_q <= 1'b0;
`endif
                    end
                end
                ST_WAIT: begin
                    cur_q    <= bus.cur;
                    diag_q   <= bus.diag;
                    up_q     <= bus.up;
                    left_q   <= bus.left;
                    char_a_q <= bus.char_a;
                    char_b_q <= bus.char_b;
                end
                ST_DECIDE: begin
`ifdef TRACEBACK_CHECK_EN
                    if (chk_fail) begin
                        err_q <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else
`endif
                    begin
                        dir_q   <= dec_dir;
                        out_i_q <= i;
                        out_j_q <= j;
                    end
                end
                ST_EMIT: begin
                    if (bus.out_ready) begin
                        i   <= i_step;
                        j   <= j_step;
                        len <= len + LEN_ONE;
                        if (step_last) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
